// File: rtl/mdu.sv
// Multiply/divide unit with architectural HI/LO and a fixed-latency busy window.
// Define MDU_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate ops.
module mdu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MADD  = 4'd7,
        OP_MADDU = 4'd8,
        OP_MSUB  = 4'd9,
        OP_MSUBU = 4'd10
    } op_e;

    logic [3:0]  cnt;
    op_e         op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;

    logic        launch;
    logic [3:0]  launch_len;

    logic [63:0] a_sx, b_sx, a_zx, b_zx;
    logic [63:0] smul, umul;
    logic [31:0] abs_a, abs_b, div_b, udiv_b;
    logic [31:0] q_mag, r_mag, squo, srem, uquo, urem;
    logic [63:0] res;
    logic        res_valid;

    assign busy = (cnt != 4'd0);

    always_comb begin
        launch     = 1'b0;
        launch_len = '0;
        if (start && !busy) begin
            case (md_op)
                OP_MULT, OP_MULTU: begin
                    launch     = 1'b1;
                    launch_len = 4'd5;
                end
                OP_DIV, OP_DIVU: begin
                    launch     = 1'b1;
                    launch_len = 4'd10;
                end
`ifdef MDU_MADD_EN
                OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                    launch     = 1'b1;
                    launch_len = 4'd5;
                end
`endif
                default: ;
            endcase
        end
    end

    // Products on sign/zero-extended operands; the low 64 bits are exact.
    assign a_sx = {{32{a_q[31]}}, a_q};
    assign b_sx = {{32{b_q[31]}}, b_q};
    assign a_zx = {32'd0, a_q};
    assign b_zx = {32'd0, b_q};
    assign smul = a_sx * b_sx;
    assign umul = a_zx * b_zx;

    // Signed divide via magnitudes so 0x80000000 / -1 wraps to 0x80000000.
    assign abs_a  = a_q[31] ? (~a_q + 32'd1) : a_q;
    assign abs_b  = b_q[31] ? (~b_q + 32'd1) : b_q;
    assign div_b  = (b_q == 32'd0) ? 32'd1 : abs_b;
    assign udiv_b = (b_q == 32'd0) ? 32'd1 : b_q;
    assign q_mag  = abs_a / div_b;
    assign r_mag  = abs_a % div_b;
    assign squo   = (a_q[31] ^ b_q[31]) ? (~q_mag + 32'd1) : q_mag;
    assign srem   = a_q[31] ? (~r_mag + 32'd1) : r_mag;
    assign uquo   = a_q / udiv_b;
    assign urem   = a_q % udiv_b;

    always_comb begin
        res       = {hi, lo};
        res_valid = 1'b0;
        case (op_q)
            OP_MULT: begin
                res       = smul;
                res_valid = 1'b1;
            end
            OP_MULTU: begin
                res       = umul;
                res_valid = 1'b1;
            end
            OP_DIV: begin
                res       = {srem, squo};
                res_valid = (b_q != 32'd0);
            end
            OP_DIVU: begin
                res       = {urem, uquo};
                res_valid = (b_q != 32'd0);
            end
`ifdef MDU_MADD_EN
            OP_MADD: begin
                res       = {hi, lo} + smul;
                res_valid = 1'b1;
            end
            OP_MADDU: begin
                res       = {hi, lo} + umul;
                res_valid = 1'b1;
            end
            OP_MSUB: begin
                res       = {hi, lo} - smul;
                res_valid = 1'b1;
            end
            OP_MSUBU: begin
                res       = {hi, lo} - umul;
                res_valid = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            op_q <= OP_NOP;
            a_q  <= '0;
            b_q  <= '0;
            hi   <= '0;
            lo   <= '0;
        end else if (busy) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1 && res_valid) begin
                hi <= res[63:32];
                lo <= res[31:0];
            end
        end else if (launch) begin
            cnt  <= launch_len;
            op_q <= op_e'(md_op);
            a_q  <= a;
            b_q  <= b;
        end else if (md_op == OP_MTHI) begin
            hi <= a;
        end else if (md_op == OP_MTLO) begin
            lo <= a;
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Directed-vector bench for mdu: latency windows, results, hazards, reset abort.
module tb_mdu;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    mdu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .md_op (md_op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        md_op = op;
        a     = x;
        b     = y;
        tick();
        start = 1'b0;
        md_op = 4'd0;
    endtask

    // Expects n busy cycles with HI/LO held, then busy low.
    task automatic expect_window(input string tag, input int unsigned n,
                                 input logic [31:0] old_hi, input logic [31:0] old_lo);
        for (int unsigned i = 0; i < n; i++) begin
            check({tag, "_busy"}, {31'd0, busy}, 32'd1);
            if (i == n - 1) begin
                check({tag, "_hold_hi"}, hi, old_hi);
                check({tag, "_hold_lo"}, lo, old_lo);
            end
            tick();
        end
        check({tag, "_done"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        md_op = 4'd0;
        a     = '0;
        b     = '0;
        #12;
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        tick();

        // MULT -2 * 3
        issue(4'd1, 32'hFFFF_FFFE, 32'd3);
        expect_window("mult", 5, 32'd0, 32'd0);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);

        // DIV -7 / 2
        issue(4'd3, 32'hFFFF_FFF9, 32'd2);
        expect_window("div", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        // DIVU by zero keeps HI=1, LO=2
        md_op = 4'd5; a = 32'd1; tick();
        md_op = 4'd6; a = 32'd2; tick();
        md_op = 4'd0;
        check("mt_hi", hi, 32'd1);
        check("mt_lo", lo, 32'd2);
        issue(4'd4, 32'd7, 32'd0);
        expect_window("divu0", 10, 32'd1, 32'd2);
        check("divu0_hi", hi, 32'd1);
        check("divu0_lo", lo, 32'd2);

        // signed overflow corner
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        expect_window("divovf", 10, 32'd1, 32'd2);
        check("divovf_lo", lo, 32'h8000_0000);
        check("divovf_hi", hi, 32'd0);

        issue(4'd4, 32'd100, 32'd7);
        expect_window("divu", 10, 32'd0, 32'h8000_0000);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        // 7 / -2 -> q=-3, r=1
        issue(4'd3, 32'd7, 32'hFFFF_FFFE);
        expect_window("divneg", 10, 32'd2, 32'd14);
        check("divneg_lo", lo, 32'hFFFF_FFFD);
        check("divneg_hi", hi, 32'd1);

        // MULTU with a start/DIV pulse and operand change during busy
        issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("haz_b0", {31'd0, busy}, 32'd1);
        tick();
        check("haz_b1", {31'd0, busy}, 32'd1);
        start = 1'b1; md_op = 4'd3; a = 32'd10; b = 32'd3;
        tick();
        check("haz_b2", {31'd0, busy}, 32'd1);
        start = 1'b0; md_op = 4'd0; a = 32'd1; b = 32'd1;
        tick();
        check("haz_b3", {31'd0, busy}, 32'd1);
        tick();
        check("haz_b4", {31'd0, busy}, 32'd1);
        check("haz_hold_lo", lo, 32'hFFFF_FFFD);
        tick();
        check("haz_done", {31'd0, busy}, 32'd0);
        check("haz_hi", hi, 32'hFFFF_FFFE);
        check("haz_lo", lo, 32'h0000_0001);
        tick();
        check("haz_norelaunch", {31'd0, busy}, 32'd0);

        // MTHI with start high while idle
        start = 1'b1; md_op = 4'd5; a = 32'h1234_5678;
        tick();
        start = 1'b0; md_op = 4'd0;
        check("mthi", hi, 32'h1234_5678);
        check("mthi_busy", {31'd0, busy}, 32'd0);

        // MTLO ignored while busy
        issue(4'd1, 32'd2, 32'd3);
        md_op = 4'd6; a = 32'hDEAD_BEEF;
        tick();
        md_op = 4'd0;
        check("mtlo_busy_lo", lo, 32'd1);
        expect_window("mult2", 4, 32'h1234_5678, 32'd1);
        check("mult2_hi", hi, 32'd0);
        check("mult2_lo", lo, 32'd6);

        // undefined op with start
        issue(4'd15, 32'd9, 32'd9);
        check("undef_busy", {31'd0, busy}, 32'd0);
        check("undef_lo", lo, 32'd6);

        // reset in busy cycle 4 of a DIV
        issue(4'd3, 32'd100, 32'd5);
        tick(); tick(); tick();
        check("rstop_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rstop_hi", hi, 32'd0);
        check("rstop_lo", lo, 32'd0);
        check("rstop_busyclr", {31'd0, busy}, 32'd0);
        #2;
        rst_n = 1'b1;
        start = 1'b1; md_op = 4'd1; a = 32'd7; b = 32'd6;
        tick();
        start = 1'b0; md_op = 4'd0;
        expect_window("postrst", 5, 32'd0, 32'd0);
        check("postrst_lo", lo, 32'd42);
        check("postrst_hi", hi, 32'd0);
        tick(); tick(); tick(); tick(); tick();
        check("postrst_nowrite_lo", lo, 32'd42);
        check("postrst_nowrite_hi", hi, 32'd0);

        // accumulate ops
        md_op = 4'd5; a = 32'd0; tick();
        md_op = 4'd6; a = 32'hFFFF_FFFF; tick();
        md_op = 4'd0;
`ifdef MDU_MADD_EN
        issue(4'd8, 32'd1, 32'd1);
        expect_window("maddu", 5, 32'd0, 32'hFFFF_FFFF);
        check("maddu_hi", hi, 32'd1);
        check("maddu_lo", lo, 32'd0);
        issue(4'd9, 32'hFFFF_FFFF, 32'd2);
        expect_window("msub", 5, 32'd1, 32'd0);
        check("msub_hi", hi, 32'd1);
        check("msub_lo", lo, 32'd2);
`else
        issue(4'd8, 32'd1, 32'd1);
        check("maddu_off_busy", {31'd0, busy}, 32'd0);
        tick(); tick(); tick(); tick(); tick();
        check("maddu_off_busy2", {31'd0, busy}, 32'd0);
        check("maddu_off_hi", hi, 32'd0);
        check("maddu_off_lo", lo, 32'hFFFF_FFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
